pwm_peripheral: RTL and testbench

//  Output stage downstream of the SPI register block. Consumes the five
//  SPI-written config registers and drives 16 outputs. Each output is off,

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_timebase.sv | 38 +++
 rtl/pwm_peripheral.sv | 77 +++++++
 tb/tb_pwm_peripheral.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
package pwm_pkg;

  localparam int PWM_BITS        = 8;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int NUM_OUT         = 16;

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  typedef logic [NUM_OUT-1:0] out_vec_t;

  // Per-bit output select: enable dominates, then PWM vs static-on.
  function automatic out_vec_t out_mux(input out_vec_t en_out,
                                       input out_vec_t en_pwm,
                                       input logic     pwm_sig);
    out_vec_t res;
    for (int i = 0; i < NUM_OUT; i++) begin
      res[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1'b1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler plus period counter, with a strobe that
// marks the first clk of every period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int PWM_BITS = pwm_pkg::PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PWM_BITS-1:0] cnt,
  output logic                period_start_comb
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  // Prescaler counts 0..CLK_DIV-1; period counter advances on its wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      cnt   <= cnt + PWM_BITS'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // True in the very first clk after reset release and at every wrap to zero.
  assign period_start_comb = (cnt == '0) && (presc == '0);

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 outputs, each off, statically on, or driven by a
// shared PWM waveform whose duty is latched only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int PWM_BITS = pwm_pkg::PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [PWM_BITS-1:0] pwm_duty_cycle,
  output logic [15:0]         out,
  output logic                period_start
);

  logic [PWM_BITS-1:0] cnt;
  logic                period_start_comb;
  logic [PWM_BITS-1:0] duty_shadow;
  logic [PWM_BITS-1:0] duty_eff;
  logic                pwm_sig;
  out_vec_t            en_out;
  out_vec_t            en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV  (CLK_DIV),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk               (clk),
    .rst_n             (rst_n),
    .cnt               (cnt),
    .period_start_comb (period_start_comb)
  );

  // Duty shadow: captured only at period start so mid-period writes never
  // glitch the running waveform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (period_start_comb) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  // Comparator; in the period-start clk the freshly captured duty is used so
  // the whole new period, including its first count, follows the new value.
  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    duty_eff = period_start_comb ? pwm_duty_cycle : duty_shadow;
    if (duty_eff == DUTY_FULL) begin
      pwm_sig = 1'b1;
    end else if (duty_eff == '0) begin
      pwm_sig = 1'b0;
    end else begin
      pwm_sig = (cnt < duty_eff);
    end
  end

  // Registered outputs and period-start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_mux(en_out, en_pwm, pwm_sig);
      period_start <= period_start_comb;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed testbench for pwm_peripheral (CLK_DIV=13, 256 counts/period).
module tb_pwm_peripheral;

  localparam int PERIOD_CLKS = 13 * 256;   // 3328
  localparam int COUNT_CLKS  = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int checks   = 0;
  int failures = 0;

  pwm_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Advance negedges until period_start is seen (bounded).
  task automatic align(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (period_start === 1'b1);
  endtask

  // Starting at a negedge with period_start=1, walk one period and stop at
  // the next period_start. Optionally write new_duty at offset change_at.
  task automatic measure_period(input int change_at, input logic [7:0] new_duty,
                                output int len, output int high, output int bad);
    len = 0; high = 0; bad = 0;
    do begin
      if (out === 16'hFFFF) high++;
      else if (out !== 16'h0000) bad++;
      if (len == change_at) pwm_duty_cycle = new_duty;
      len++;
      @(negedge clk);
    end while (period_start !== 1'b1 && len < 5000);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out !== 16'h0000 || period_start !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_hold: bad_cycles=%0d expected 0", bad);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_ps: got %b expected 1", period_start);
    end
    checks++;
    if (out !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_first_out: got %h expected ffff", out);
    end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ps_pulse: got %b expected 0", period_start);
    end
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_static();
    int bad;
    set_en(16'h0001, 16'h0000);
    @(negedge clk);
    checks++;
    if (out !== 16'h0001) begin
      failures++;
      $display("FAIL static_on: got %h expected 0001", out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out !== 16'h0001) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL static_on_hold: bad_cycles=%0d expected 0", bad);
    end
    set_en(16'h0000, 16'hFFFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out !== 16'h0000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL static_pwm_no_en: bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_pwm_50();
    bit ok;
    int len, high, bad;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    align(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pwm50_align: period_start timeout");
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(-1, 8'h00, len, high, bad);
      checks++;
      if (len !== PERIOD_CLKS || high !== 1664 || bad !== 0) begin
        failures++;
        $display("FAIL pwm50_p%0d: len=%0d high=%0d bad=%0d expected %0d/1664/0",
                 p, len, high, bad, PERIOD_CLKS);
      end
    end
  endtask

  task automatic test_extremes();
    int len, high, bad, tot_high, tot_len;
    // duty 0: one period to let it take effect, then three all-low periods
    pwm_duty_cycle = 8'h00;
    measure_period(-1, 8'h00, len, high, bad);
    tot_high = 0; tot_len = 0;
    for (int p = 0; p < 3; p++) begin
      measure_period(-1, 8'h00, len, high, bad);
      tot_high += high + bad;
      tot_len  += len;
    end
    checks++;
    if (tot_high !== 0 || tot_len !== 3 * PERIOD_CLKS) begin
      failures++;
      $display("FAIL duty00: high=%0d len=%0d expected 0/%0d", tot_high, tot_len, 3 * PERIOD_CLKS);
    end
    // mixed enables with pwm_sig=0: only static-on bits are high
    set_en(16'hF0F0, 16'hFF00);
    @(negedge clk); @(negedge clk);
    checks++;
    if (out !== 16'h00F0) begin
      failures++;
      $display("FAIL mixed_duty00: got %h expected 00f0", out);
    end
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    begin
      bit ok;
      align(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL dutyff_align: period_start timeout");
      end
    end
    tot_high = 0; tot_len = 0;
    for (int p = 0; p < 3; p++) begin
      measure_period(-1, 8'h00, len, high, bad);
      tot_high += high;
      tot_len  += len;
    end
    checks++;
    if (tot_high !== 3 * PERIOD_CLKS || tot_len !== 3 * PERIOD_CLKS) begin
      failures++;
      $display("FAIL dutyff: high=%0d len=%0d expected %0d/%0d",
               tot_high, tot_len, 3 * PERIOD_CLKS, 3 * PERIOD_CLKS);
    end
    set_en(16'hF0F0, 16'hFF00);
    @(negedge clk); @(negedge clk);
    checks++;
    if (out !== 16'hF0F0) begin
      failures++;
      $display("FAIL mixed_dutyff: got %h expected f0f0", out);
    end
    set_en(16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_mid_period_change();
    bit ok;
    int len, high, bad;
    pwm_duty_cycle = 8'h40;
    align(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midchg_align: period_start timeout");
    end
    // offset 1300 from the period_start sample is cnt=100
    measure_period(100 * COUNT_CLKS, 8'hC0, len, high, bad);
    checks++;
    if (len !== PERIOD_CLKS || high !== 832 || bad !== 0) begin
      failures++;
      $display("FAIL midchg_cur: len=%0d high=%0d bad=%0d expected %0d/832/0",
               len, high, bad, PERIOD_CLKS);
    end
    measure_period(-1, 8'h00, len, high, bad);
    checks++;
    if (len !== PERIOD_CLKS || high !== 2496 || bad !== 0) begin
      failures++;
      $display("FAIL midchg_next: len=%0d high=%0d bad=%0d expected %0d/2496/0",
               len, high, bad, PERIOD_CLKS);
    end
  endtask

  task automatic test_reset_mid_period();
    int len, high, bad;
    // currently at a period_start with duty C0; go to cnt=50 (high phase)
    for (int i = 0; i < 50 * COUNT_CLKS; i++) @(negedge clk);
    checks++;
    if (out !== 16'hFFFF) begin
      failures++;
      $display("FAIL rstmid_pre: got %h expected ffff", out);
    end
    #2 rst_n = 1'b0;
    pwm_duty_cycle = 8'h40;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: out=%h ps=%b expected 0000/0", out, period_start);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_first_ps: got %b expected 1", period_start);
    end
    measure_period(-1, 8'h00, len, high, bad);
    checks++;
    if (len !== PERIOD_CLKS || high !== 832 || bad !== 0) begin
      failures++;
      $display("FAIL rstmid_period: len=%0d high=%0d bad=%0d expected %0d/832/0",
               len, high, bad, PERIOD_CLKS);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm_50();
    test_extremes();
    test_mid_period_change();
    test_reset_mid_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
